// File: rtl/priority_arbiter_rr.sv
// Registered N-way arbiter: fixed-priority or round-robin winner selection,
// grant held until the winner acknowledges or drops its request.
module priority_arbiter_rr #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] LAST = W'(N - 1);

  state_e         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [W-1:0]   idx_q, idx_d;
  logic [W-1:0]   ptr_q, ptr_d;

  logic           win_found;
  logic [W-1:0]   win_idx;
  int             scan_j;
  logic           release_c;

  // Round-robin scan index wraps at N, not at 2**W.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_j    = 0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          win_found = 1'b1;
          win_idx   = W'(i);
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        scan_j = int'(ptr_q) + k;
        if (scan_j >= N) scan_j = scan_j - N;
        if (!win_found && req[scan_j]) begin
          win_found = 1'b1;
          win_idx   = W'(scan_j);
        end
      end
    end
  end

  assign release_c = ack || !req[idx_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (enable && win_found) begin
          state_d = GRANT;
          grant_d = ONE << win_idx;
          idx_d   = win_idx;
        end
      end
      GRANT: begin
        if (release_c) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (idx_q == LAST) ? '0 : idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign valid     = (state_q == GRANT);

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Directed vector bench for priority_arbiter_rr at N=4 and N=5.
module tb_priority_arbiter_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, en4, mode4, ack4;
  logic [3:0] req4;
  logic [3:0] g4;
  logic [1:0] i4;
  logic       v4;

  logic       rst5, en5, mode5, ack5;
  logic [4:0] req5;
  logic [4:0] g5;
  logic [2:0] i5;
  logic       v5;

  priority_arbiter_rr #(.N(4)) dut4 (
    .clk(clk), .reset(rst4), .enable(en4), .mode(mode4),
    .req(req4), .ack(ack4),
    .grant(g4), .grant_idx(i4), .valid(v4)
  );

  priority_arbiter_rr #(.N(5)) dut5 (
    .clk(clk), .reset(rst5), .enable(en5), .mode(mode5),
    .req(req5), .ack(ack5),
    .grant(g5), .grant_idx(i5), .valid(v5)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       md;
    logic [3:0] rq;
    logic       ak;
    logic [3:0] eg;
    logic [1:0] ei;
    logic       ev;
  } vec_t;

  vec_t vq[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic m,
                     input logic [3:0] q, input logic a,
                     input logic [3:0] g, input logic [1:0] i,
                     input logic v);
    vec_t t;
    t.rst = r; t.en = e; t.md = m; t.rq = q; t.ak = a;
    t.eg = g; t.ei = i; t.ev = v;
    vq.push_back(t);
  endtask

  task automatic step5(input string nm, input logic r, input logic e,
                       input logic m, input logic [4:0] q, input logic a,
                       input logic [4:0] g, input logic [2:0] i,
                       input logic v);
    @(negedge clk);
    rst5 = r; en5 = e; mode5 = m; req5 = q; ack5 = a;
    @(posedge clk);
    #1;
    chk({nm, ".grant"}, 32'(g5), 32'(g));
    chk({nm, ".idx"}, 32'(i5), 32'(i));
    chk({nm, ".valid"}, 32'(v5), 32'(v));
    chk({nm, ".onehot"}, 32'($onehot0(g5)), 32'd1);
  endtask

  initial begin
    rst4 = 1'b1; en4 = 1'b0; mode4 = 1'b0; req4 = '0; ack4 = 1'b0;
    rst5 = 1'b1; en5 = 1'b0; mode5 = 1'b0; req5 = '0; ack5 = 1'b0;

    //  rst en md req     ack  grant   idx v
    add(1, 0, 0, 4'b0000, 0, 4'b0000, 0, 0);
    add(0, 1, 0, 4'b1011, 0, 4'b1000, 3, 1);
    add(0, 1, 0, 4'b1011, 1, 4'b0000, 3, 0);
    add(0, 1, 1, 4'b1111, 0, 4'b0001, 0, 1);
    add(0, 1, 1, 4'b1111, 1, 4'b0000, 0, 0);
    add(0, 1, 1, 4'b1111, 0, 4'b0010, 1, 1);
    add(0, 1, 1, 4'b1111, 1, 4'b0000, 1, 0);
    add(0, 1, 1, 4'b1111, 0, 4'b0100, 2, 1);
    add(0, 1, 1, 4'b1111, 1, 4'b0000, 2, 0);
    add(0, 1, 1, 4'b1111, 0, 4'b1000, 3, 1);
    add(0, 1, 1, 4'b1111, 1, 4'b0000, 3, 0);
    add(0, 1, 1, 4'b1111, 0, 4'b0001, 0, 1);
    add(0, 1, 1, 4'b1111, 1, 4'b0000, 0, 0);
    add(0, 1, 1, 4'b0100, 0, 4'b0100, 2, 1);
    add(0, 0, 0, 4'b0100, 0, 4'b0100, 2, 1);
    add(0, 1, 0, 4'b1100, 0, 4'b0100, 2, 1);
    add(0, 0, 1, 4'b1000, 0, 4'b0000, 2, 0);
    add(0, 0, 0, 4'b0110, 0, 4'b0000, 2, 0);
    add(0, 0, 0, 4'b0110, 0, 4'b0000, 2, 0);
    add(0, 1, 0, 4'b0110, 0, 4'b0100, 2, 1);
    add(0, 1, 0, 4'b0110, 1, 4'b0000, 2, 0);
    add(0, 1, 0, 4'b0000, 0, 4'b0000, 2, 0);
    add(0, 1, 1, 4'b0010, 0, 4'b0010, 1, 1);
    add(1, 1, 1, 4'b0010, 1, 4'b0000, 0, 0);
    add(0, 1, 1, 4'b1111, 0, 4'b0001, 0, 1);
    add(0, 1, 1, 4'b1110, 1, 4'b0000, 0, 0);
    add(0, 1, 1, 4'b1111, 0, 4'b0010, 1, 1);
    add(0, 1, 1, 4'b1111, 1, 4'b0000, 1, 0);
    add(0, 0, 1, 4'b1111, 1, 4'b0000, 1, 0);
    add(0, 1, 1, 4'b1001, 0, 4'b1000, 3, 1);
    add(0, 1, 1, 4'b1001, 1, 4'b0000, 3, 0);
    add(0, 1, 1, 4'b1001, 1, 4'b0001, 0, 1);
    add(0, 1, 1, 4'b1001, 0, 4'b0001, 0, 1);
    add(0, 1, 1, 4'b1001, 1, 4'b0000, 0, 0);

    for (int n = 0; n < vq.size(); n++) begin
      @(negedge clk);
      rst4 = vq[n].rst; en4 = vq[n].en; mode4 = vq[n].md;
      req4 = vq[n].rq;  ack4 = vq[n].ak;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.grant", n), 32'(g4), 32'(vq[n].eg));
      chk($sformatf("v%0d.idx", n), 32'(i4), 32'(vq[n].ei));
      chk($sformatf("v%0d.valid", n), 32'(v4), 32'(vq[n].ev));
      chk($sformatf("v%0d.onehot", n), 32'($onehot0(g4)), 32'd1);
    end

    // N=5: wrap of ptr from 4 to 0 on a non-power-of-two size
    step5("n5.rst",  1, 0, 0, 5'b00000, 0, 5'b00000, 0, 0);
    step5("n5.g0",   0, 1, 1, 5'b10001, 0, 5'b00001, 0, 1);
    step5("n5.r0",   0, 1, 1, 5'b10001, 1, 5'b00000, 0, 0);
    step5("n5.g4",   0, 1, 1, 5'b10001, 0, 5'b10000, 4, 1);
    step5("n5.r4",   0, 1, 1, 5'b10001, 1, 5'b00000, 4, 0);
    step5("n5.wrap", 0, 1, 1, 5'b10001, 0, 5'b00001, 0, 1);
    step5("n5.r0b",  0, 1, 1, 5'b00000, 0, 5'b00000, 0, 0);
    step5("n5.fix",  0, 1, 0, 5'b10011, 0, 5'b10000, 4, 1);
    step5("n5.drop", 0, 1, 0, 5'b00011, 0, 5'b00000, 4, 0);
    step5("n5.rr",   0, 1, 1, 5'b01110, 0, 5'b00010, 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
